// File: rtl/score_bcd_display_pkg.sv
// Shared types and constants for the score BCD display: FSM states, segment
// patterns (active-low, bit0=a .. bit6=g) and the double-dabble nibble adjust.
package score_bcd_display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;

    localparam logic [3:0] SHIFT_STEPS = 4'd8;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] acc);
        logic [11:0] res;
        for (int i = 0; i < 3; i++) begin
            res[i*4 +: 4] = (acc[i*4 +: 4] >= 4'd5) ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
        end
        return res;
    endfunction

endpackage

// File: rtl/score_bcd_display_seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern.
// Non-decimal nibbles produce a blank digit.
module seg7_decoder
    import score_bcd_display_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_bcd_display.sv
// Converts an 8-bit score to three BCD digits with a serial double-dabble FSM
// and drives three registered seven-segment displays.
module score_bcd_display
    import score_bcd_display_pkg::*;
#(
    parameter int BLANK_LEADING = 1
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  score,
    output logic [11:0] bcd,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        valid,
    output logic        busy,
    output state_t      dbg_state
);

    state_t      r_state;
    logic [11:0] r_acc;
    logic [7:0]  r_sr;
    logic [3:0]  r_cnt;
    logic [7:0]  r_last_score;
    logic        r_force;

    logic [11:0] w_adj;
    logic [19:0] w_next;
    logic [6:0]  w_seg2;
    logic [6:0]  w_seg1;
    logic [6:0]  w_seg0;
    logic        w_blank2;
    logic        w_blank1;

    assign w_adj  = dabble_adjust(r_acc);
    assign w_next = {w_adj, r_sr} << 1;

    seg7_decoder u_dec2 (.i_digit(r_acc[11:8]), .o_seg(w_seg2));
    seg7_decoder u_dec1 (.i_digit(r_acc[7:4]),  .o_seg(w_seg1));
    seg7_decoder u_dec0 (.i_digit(r_acc[3:0]),  .o_seg(w_seg0));

    // Tens is only suppressed when hundreds is suppressed too, so "105" keeps its 0.
    assign w_blank2 = (BLANK_LEADING != 0) && (r_acc[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (r_acc[7:4] == 4'd0);

    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_last_score <= '0;
            r_force      <= 1'b1;
            bcd          <= '0;
            hex2         <= SEG_BLANK;
            hex1         <= SEG_BLANK;
            hex0         <= SEG_BLANK;
            valid        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if ((score != r_last_score) || r_force) begin
                        r_sr         <= score;
                        r_last_score <= score;
                        r_force      <= 1'b0;
                        r_acc        <= '0;
                        r_cnt        <= SHIFT_STEPS;
                        busy         <= 1'b1;
                        r_state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_acc <= w_next[19:8];
                    r_sr  <= w_next[7:0];
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    bcd     <= r_acc;
                    hex2    <= w_blank2 ? SEG_BLANK : w_seg2;
                    hex1    <= w_blank1 ? SEG_BLANK : w_seg1;
                    hex0    <= w_seg0;
                    valid   <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
